// File: rtl/tile_load_sequencer_if.sv
// ---------------------------------------------------------------------------
// tile_load_sequencer_if
//   Bundles every non-clock signal of the tile load sequencer.
//   The sequencer connects through the slave modport; the host / accelerator
//   model connects through the master modport.
//
//   Control : start, ifmap_words, wght_words, ofmap_words -> busy, done
//   Stream in  (host -> seq) : in_valid, in_data, in_ready
//   Stream out (seq -> host) : out_valid, out_data, out_ready
//   Accelerator side         : config/bias/op strobes, ifmap/wght write ports,
//                              ofmap read port, dataload_ready, tile_done
//   Parameter wd : datapath word width; data buses are 8*wd bits.
// ---------------------------------------------------------------------------
interface tile_load_sequencer_if #(
    parameter int wd = 8
);
    logic              start;
    logic [9:0]        ifmap_words;
    logic [9:0]        wght_words;
    logic [9:0]        ofmap_words;

    logic              in_valid;
    logic [8*wd-1:0]   in_data;
    logic              in_ready;

    logic              out_valid;
    logic [8*wd-1:0]   out_data;
    logic              out_ready;

    logic              config_load;
    logic              config_done;
    logic              bias_write;
    logic              op_go;
    logic              op_done;
    logic              ifmap_ready;
    logic              wght_ready;
    logic              ifmap_en;
    logic              wght_en;
    logic              ofmap_en;
    logic [7:0]        ifmap_wen;
    logic [7:0]        wght_wen;
    logic [9:0]        ifmap_addrin;
    logic [9:0]        wght_addrin;
    logic [9:0]        ofmap_addrin;
    logic [8*wd-1:0]   ifmap_din;
    logic [8*wd-1:0]   wght_din;

    logic              dataload_ready;
    logic              tile_done;
    logic [8*wd-1:0]   ofmap_dout;

    logic              busy;
    logic              done;

    modport slave (
        input  start, ifmap_words, wght_words, ofmap_words,
        input  in_valid, in_data, output in_ready,
        output out_valid, out_data, input out_ready,
        output config_load, config_done, bias_write, op_go, op_done,
        output ifmap_ready, wght_ready, ifmap_en, wght_en, ofmap_en,
        output ifmap_wen, wght_wen, ifmap_addrin, wght_addrin, ofmap_addrin,
        output ifmap_din, wght_din,
        input  dataload_ready, tile_done, ofmap_dout,
        output busy, done
    );

    modport master (
        output start, ifmap_words, wght_words, ofmap_words,
        output in_valid, in_data, input in_ready,
        input  out_valid, out_data, output out_ready,
        input  config_load, config_done, bias_write, op_go, op_done,
        input  ifmap_ready, wght_ready, ifmap_en, wght_en, ofmap_en,
        input  ifmap_wen, wght_wen, ifmap_addrin, wght_addrin, ofmap_addrin,
        input  ifmap_din, wght_din,
        output dataload_ready, tile_done, ofmap_dout,
        input  busy, done
    );
endinterface

// File: rtl/tile_load_sequencer.sv
// ---------------------------------------------------------------------------
// tile_load_sequencer
//   Drives one accelerator tile: configure, stream bias/weights/ifmap from an
//   input stream into the accelerator buffers, launch the operation, wait for
//   completion and stream the ofmap buffer back out.
//
//   Ports
//     clk  : single clock, rising edge
//     rst  : asynchronous active-high reset (forces IDLE, all outputs 0)
//     sif  : tile_load_sequencer_if.slave (control, streams, accel ports)
//
//   Optional feature macro: SEQ_BIAS_LOAD_EN
//     defined   -> a BIAS phase loads 2 stream words into the weight buffer
//                  (addresses 0..1) with bias_write asserted, before WGHT.
//     undefined -> no BIAS phase, CFG goes straight to WGHT, bias_write = 0.
//
//   All accelerator strobes are decoded combinationally from the state
//   register, so an asserted rst zeroes them in the same cycle.
// ---------------------------------------------------------------------------
module tile_load_sequencer #(
    parameter int wd = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    tile_load_sequencer_if.slave  sif
);

    typedef enum logic [3:0] {
        IDLE,
        CFG,
`ifdef SEQ_BIAS_LOAD_EN
        BIAS,
`endif
        WGHT,
        IFMAP,
        GO,
        RUN,
        RD_ADDR,
        RD_DATA,
        FIN
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_cfg_ph;      // 0: config_load cycle, 1: config_done cycle
    logic            w_cfg_ph_nxt;
    logic [9:0]      r_cnt;         // word index shared by all phases
    logic [9:0]      w_cnt_nxt;
    logic [10:0]     w_cnt_inc;     // one bit wider so 1023+1 cannot wrap
    logic [9:0]      r_ifmap_words;
    logic [9:0]      r_wght_words;
    logic [9:0]      r_ofmap_words;
    logic [8*wd-1:0] r_out_data;
    logic            w_accept;

    assign w_cnt_inc    = {1'b0, r_cnt} + 11'd1;
    assign w_accept     = sif.in_valid & sif.in_ready;
    assign sif.out_data = r_out_data;
    assign sif.busy     = (r_state != IDLE);

    // -----------------------------------------------------------------------
    // State and counter registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cfg_ph      <= 1'b0;
            r_cnt         <= '0;
            r_ifmap_words <= '0;
            r_wght_words  <= '0;
            r_ofmap_words <= '0;
        end else begin
            r_state  <= w_next;
            r_cfg_ph <= w_cfg_ph_nxt;
            r_cnt    <= w_cnt_nxt;
            if (r_state == IDLE && sif.start) begin
                r_ifmap_words <= sif.ifmap_words;
                r_wght_words  <= sif.wght_words;
                r_ofmap_words <= sif.ofmap_words;
            end
        end
    end

    // The ofmap buffer returns data one cycle after the address; capturing
    // on the RD_ADDR -> RD_DATA edge holds the word stable for as long as
    // the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
        end else if (r_state == RD_ADDR) begin
            r_out_data <= sif.ofmap_dout;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_next           = r_state;
        w_cfg_ph_nxt     = 1'b0;
        w_cnt_nxt        = r_cnt;

        sif.in_ready     = 1'b0;
        sif.out_valid    = 1'b0;
        sif.config_load  = 1'b0;
        sif.config_done  = 1'b0;
        sif.bias_write   = 1'b0;
        sif.op_go        = 1'b0;
        sif.op_done      = 1'b0;
        sif.ifmap_ready  = 1'b0;
        sif.wght_ready   = 1'b0;
        sif.ifmap_en     = 1'b0;
        sif.wght_en      = 1'b0;
        sif.ofmap_en     = 1'b0;
        sif.ifmap_wen    = 8'h00;
        sif.wght_wen     = 8'h00;
        sif.ifmap_addrin = '0;
        sif.wght_addrin  = '0;
        sif.ofmap_addrin = '0;
        sif.ifmap_din    = '0;
        sif.wght_din     = '0;
        sif.done         = 1'b0;

        case (r_state)
            IDLE: begin
                if (sif.start) begin
                    w_next    = CFG;
                    w_cnt_nxt = '0;
                end
            end

            CFG: begin
                if (!r_cfg_ph) begin
                    sif.config_load = 1'b1;
                    w_cfg_ph_nxt    = 1'b1;
                end else begin
                    sif.config_done = 1'b1;
                    w_cnt_nxt       = '0;
`ifdef SEQ_BIAS_LOAD_EN
                    w_next          = BIAS;
`else
                    w_next          = WGHT;
`endif
                end
            end

`ifdef SEQ_BIAS_LOAD_EN
            // Bias occupies weight buffer words 0..1; no ready pulse here.
            BIAS: begin
                sif.in_ready = 1'b1;
                if (w_accept) begin
                    sif.bias_write  = 1'b1;
                    sif.wght_en     = 1'b1;
                    sif.wght_wen    = 8'hFF;
                    sif.wght_addrin = r_cnt;
                    sif.wght_din    = sif.in_data;
                    if (r_cnt == 10'd1) begin
                        w_next    = WGHT;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc[9:0];
                    end
                end
            end
`endif

            // Once the index reaches the count (immediately for a count of
            // 0) the phase spends one cycle on the ready pulse.
            WGHT: begin
                if (r_cnt == r_wght_words) begin
                    sif.wght_ready = 1'b1;
                    w_next         = IFMAP;
                    w_cnt_nxt      = '0;
                end else begin
                    sif.in_ready = 1'b1;
                    if (w_accept) begin
                        sif.wght_en     = 1'b1;
                        sif.wght_wen    = 8'hFF;
                        sif.wght_addrin = r_cnt;
                        sif.wght_din    = sif.in_data;
                        w_cnt_nxt       = w_cnt_inc[9:0];
                    end
                end
            end

            IFMAP: begin
                if (r_cnt == r_ifmap_words) begin
                    sif.ifmap_ready = 1'b1;
                    w_next          = GO;
                    w_cnt_nxt       = '0;
                end else begin
                    sif.in_ready = 1'b1;
                    if (w_accept) begin
                        sif.ifmap_en     = 1'b1;
                        sif.ifmap_wen    = 8'hFF;
                        sif.ifmap_addrin = r_cnt;
                        sif.ifmap_din    = sif.in_data;
                        w_cnt_nxt        = w_cnt_inc[9:0];
                    end
                end
            end

            GO: begin
                if (sif.dataload_ready) begin
                    sif.op_go = 1'b1;
                    w_next    = RUN;
                end
            end

            RUN: begin
                if (sif.tile_done) begin
                    w_cnt_nxt = '0;
                    w_next    = (r_ofmap_words == 10'd0) ? FIN : RD_ADDR;
                end
            end

            RD_ADDR: begin
                sif.ofmap_en     = 1'b1;
                sif.ofmap_addrin = r_cnt;
                w_next           = RD_DATA;
            end

            RD_DATA: begin
                sif.out_valid = 1'b1;
                if (sif.out_ready) begin
                    if (w_cnt_inc < {1'b0, r_ofmap_words}) begin
                        w_cnt_nxt = w_cnt_inc[9:0];
                        w_next    = RD_ADDR;
                    end else begin
                        w_next    = FIN;
                    end
                end
            end

            FIN: begin
                sif.op_done = 1'b1;
                sif.done    = 1'b1;
                w_next      = IDLE;
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tile_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tile_load_sequencer
//   Directed bench for tile_load_sequencer. A negedge monitor checks every
//   buffer write / read word against bench-side indices and a fixed ofmap
//   memory pattern, and counts strobes per run; the main sequence checks
//   those counts, latencies and reset behaviour.
// ---------------------------------------------------------------------------
module tb_tile_load_sequencer;
    localparam int WD = 8;
    localparam int DW = 8 * WD;
`ifdef SEQ_BIAS_LOAD_EN
    localparam int NB = 2;
`else
    localparam int NB = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tile_load_sequencer_if #(.wd(WD)) sif ();
    tile_load_sequencer #(.wd(WD)) dut (.clk(clk), .rst(rst), .sif(sif));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // ofmap buffer model: combinational read of a fixed per-address pattern
    function automatic logic [DW-1:0] rd_word(input logic [9:0] a);
        logic [7:0] b;
        b = a[7:0] ^ 8'hA5;
        return {8{b}};
    endfunction
    assign sif.ofmap_dout = rd_word(sif.ofmap_addrin);

    // input stream source
    logic          tb_valid = 1'b0;
    logic [DW-1:0] tb_data  = '0;
    logic          strm_on  = 1'b0;
    logic          tog_mode = 1'b0;
    int            cyc      = 0;
    assign sif.in_valid = tb_valid;
    assign sif.in_data  = tb_data;
    always @(posedge clk) begin
        #1;
        cyc++;
        tb_data  = {8{cyc[7:0]}} ^ 64'h0123_4567_89AB_CDEF;
        tb_valid = tog_mode ? ~tb_valid : strm_on;
    end

    // per-run monitor state, cleared on reset and on an accepted start
    int w_idx, i_idx, b_idx, o_idx;
    int n_cl, n_cd, n_wr, n_ir, n_go, n_od, n_dn, n_ov;
    int nb_total = 0;
    logic first_seen, first_bias;
    logic [9:0] first_addr;

    always @(negedge clk) begin
        if (rst || (sif.start && !sif.busy)) begin
            w_idx = 0; i_idx = 0; b_idx = 0; o_idx = 0;
            n_cl = 0; n_cd = 0; n_wr = 0; n_ir = 0;
            n_go = 0; n_od = 0; n_dn = 0; n_ov = 0;
            first_seen = 1'b0; first_bias = 1'b0; first_addr = '0;
        end else begin
            if (sif.config_load) n_cl++;
            if (sif.config_done) n_cd++;
            if (sif.wght_ready)  n_wr++;
            if (sif.ifmap_ready) n_ir++;
            if (sif.op_go)       n_go++;
            if (sif.op_done)     n_od++;
            if (sif.done)        n_dn++;
            if (sif.out_valid)   n_ov++;
            if (sif.bias_write)  nb_total++;
            if (sif.wght_en) begin
                if (!first_seen) begin
                    first_seen = 1'b1; first_bias = sif.bias_write; first_addr = sif.wght_addrin;
                end
                check("wght_accept", sif.in_valid & sif.in_ready, 1);
                check("wght_wen", sif.wght_wen, 8'hFF);
                check("wght_din", sif.wght_din, sif.in_data);
                if (sif.bias_write) begin
                    check("bias_addr", sif.wght_addrin, b_idx);
                    b_idx++;
                end else begin
                    check("wght_addr", sif.wght_addrin, w_idx);
                    w_idx++;
                end
            end
            if (sif.ifmap_en) begin
                check("ifmap_accept", sif.in_valid & sif.in_ready, 1);
                check("ifmap_wen", sif.ifmap_wen, 8'hFF);
                check("ifmap_din", sif.ifmap_din, sif.in_data);
                check("ifmap_addr", sif.ifmap_addrin, i_idx);
                i_idx++;
            end
            if (sif.ofmap_en) check("rd_addr", sif.ofmap_addrin, o_idx);
            if (sif.out_valid && sif.out_ready) begin
                check("out_data", sif.out_data, rd_word(o_idx[9:0]));
                o_idx++;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {sif.config_load, sif.config_done, sif.bias_write, sif.op_go,
                              sif.op_done, sif.ifmap_ready, sif.wght_ready, sif.ifmap_en,
                              sif.wght_en, sif.ofmap_en, sif.busy, sif.done, sif.in_ready,
                              sif.out_valid, sif.ifmap_wen, sif.wght_wen, sif.ifmap_addrin,
                              sif.wght_addrin, sif.ofmap_addrin}, 0);
        check({tag, "_odata"}, sif.out_data, 0);
        check({tag, "_idin"}, sif.ifmap_din, 0);
        check({tag, "_wdin"}, sif.wght_din, 0);
    endtask

    task automatic do_start(input logic [9:0] w, input logic [9:0] i, input logic [9:0] o);
        @(posedge clk); #1;
        sif.wght_words = w; sif.ifmap_words = i; sif.ofmap_words = o;
        sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
    endtask

    // latency = number of the negedge (1 = first cycle after start) with done
    task automatic wait_done(input int budget, input string tag, output int lat);
        lat = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (sif.done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check({tag, "_timeout"}, 0, 1);
        @(posedge clk); #1;
    endtask

    int lat;
    int guard;

    initial begin
        sif.start = 1'b0; sif.wght_words = '0; sif.ifmap_words = '0; sif.ofmap_words = '0;
        sif.out_ready = 1'b1; sif.dataload_ready = 1'b0; sif.tile_done = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // no strobes after reset without a start, even with accel inputs high
        sif.dataload_ready = 1'b1; sif.tile_done = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("idle_busy", sif.busy, 0);
        check("idle_strobes", n_cl + n_cd + n_go + n_dn + n_wr + n_ir, 0);

        // main flow: wght=4, ifmap=6, ofmap=3, stream always valid
        strm_on = 1'b1;
        do_start(10'd4, 10'd6, 10'd3);
        wait_done(200, "main", lat);
        check("main_latency", lat, 23 + NB);
        check("main_bias", b_idx, NB);
        check("main_wght", w_idx, 4);
        check("main_wrdy", n_wr, 1);
        check("main_ifmap", i_idx, 6);
        check("main_irdy", n_ir, 1);
        check("main_cfg", {n_cl[7:0], n_cd[7:0]}, 16'h0101);
        check("main_go", n_go, 1);
        check("main_out", o_idx, 3);
        check("main_done", {n_dn[7:0], n_od[7:0]}, 16'h0101);
        check("first_is_bias", first_bias, (NB != 0));
        check("first_addr", first_addr, 0);
        check("main_idle", sif.busy, 0);

        // in_valid toggling every cycle
        tog_mode = 1'b1;
        do_start(10'd2, 10'd6, 10'd1);
        wait_done(300, "toggle", lat);
        check("tog_ifmap", i_idx, 6);
        check("tog_wght", w_idx, 2);
        check("tog_irdy", n_ir, 1);
        tog_mode = 1'b0;
        @(posedge clk); #1;
        strm_on = 1'b1;

        // back-pressure on the first read word
        sif.out_ready = 1'b0;
        do_start(10'd1, 10'd1, 10'd2);
        guard = 0;
        while (!sif.out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("bp_reach", sif.out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", sif.out_valid, 1);
            check("bp_data", sif.out_data, rd_word(10'd0));
            check("bp_rd_hold", {sif.ofmap_en, sif.ofmap_addrin}, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        sif.out_ready = 1'b1;
        wait_done(100, "bp", lat);
        check("bp_out", o_idx, 2);

        // zero-length ifmap/ofmap; stray accel inputs must not be remembered
        sif.dataload_ready = 1'b0; sif.tile_done = 1'b0;
        do_start(10'd3, 10'd0, 10'd0);
        sif.tile_done = 1'b1; sif.dataload_ready = 1'b1;
        @(posedge clk); #1;
        sif.tile_done = 1'b0; sif.dataload_ready = 1'b0;
        guard = 0;
        while (!sif.ifmap_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("z_irdy_seen", sif.ifmap_ready, 1);
        repeat (3) @(posedge clk); #1;
        check("z_no_go", n_go, 0);
        sif.dataload_ready = 1'b1;
        @(negedge clk);
        check("z_go", sif.op_go, 1);
        @(posedge clk); #1;
        sif.dataload_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("z_run_wait", {sif.busy, n_dn[0]}, 2'b10);
        sif.tile_done = 1'b1;
        wait_done(5, "zero", lat);
        check("z_fin_latency", lat, 2);
        sif.tile_done = 1'b0;
        check("z_ifmap_wr", i_idx, 0);
        check("z_irdy", n_ir, 1);
        check("z_out_valid", n_ov, 0);
        check("z_wght", w_idx, 3);

        // reset in WGHT after 3 words, then restart
        sif.dataload_ready = 1'b1; sif.tile_done = 1'b1;
        do_start(10'd8, 10'd2, 10'd1);
        guard = 0;
        while (w_idx != 3 && guard < 100) begin
            @(posedge clk); #2;
            guard++;
        end
        check("mid_reach", w_idx, 3);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        check_all_zero("mid_rst_next");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("post_rst_strobes", n_cl + n_go + n_dn, 0);
        do_start(10'd2, 10'd1, 10'd1);
        wait_done(100, "restart", lat);
        check("restart_wght", w_idx, 2);
        check("restart_first_addr", first_addr, 0);
        check("restart_out", o_idx, 1);

        check("bias_total", nb_total, NB * 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_load_sequencer.md
TILE_LOAD_SEQUENCER -- requirements
Module: tile_load_sequencer

Interface
REQ-001 SHALL have parameter wd, default 8, meaning datapath word width; all data buses are 8*wd bits.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports start in 1, ifmap_words in 10, wght_words in 10, ofmap_words in 10; the counts are sampled on start and give the number of 8*wd words per phase.
REQ-005 SHALL have stream-in ports in_valid in 1, in_data in 8*wd, in_ready out 1.
REQ-006 SHALL have stream-out ports out_valid out 1, out_data out 8*wd, out_ready in 1.
REQ-007 SHALL have accelerator-side outputs config_load, config_done, bias_write, op_go, op_done, ifmap_ready, wght_ready, ifmap_en, wght_en, ofmap_en (1 each), ifmap_wen and wght_wen (8 each), ifmap_addrin, wght_addrin and ofmap_addrin (10 each), and ifmap_din and wght_din (8*wd each).
REQ-008 SHALL have accelerator-side inputs dataload_ready in 1, tile_done in 1, ofmap_dout in 8*wd.
REQ-009 SHALL have status outputs busy out 1 and done out 1.

Function
REQ-010 SHALL implement the states IDLE, CFG, BIAS, WGHT, IFMAP, GO, RUN, RD_ADDR, RD_DATA and FIN.
REQ-011 In IDLE, start=1 SHALL latch the counts, clear the word counter and enter CFG; start is ignored in every other state.
REQ-012 CFG SHALL assert config_load for exactly 1 cycle, then config_done for 1 cycle, then enter BIAS.
REQ-013 BIAS SHALL accept exactly 2 stream words, with bias_write=1, wght_en=1, wght_wen=8'hFF, wght_addrin=word index 0..1 and wght_din=in_data, and SHALL then enter WGHT.
REQ-014 WGHT SHALL accept wght_words words, with wght_en=1, wght_wen=8'hFF, wght_addrin=0..wght_words-1 and wght_din=in_data, and SHALL then pulse wght_ready for 1 cycle and enter IFMAP.
REQ-015 IFMAP SHALL accept ifmap_words words in the same manner on the ifmap_* ports, and SHALL then pulse ifmap_ready for 1 cycle and enter GO.
REQ-016 A word SHALL be accepted only in a cycle where in_valid and in_ready are both 1; write enables SHALL be asserted only in accepting cycles; the address SHALL increment once per accepted word; in_ready=1 only in BIAS, WGHT and IFMAP.
REQ-017 A phase whose latched count is 0 SHALL be skipped, with no writes, while its ready pulse is still issued.
REQ-018 GO SHALL wait for dataload_ready=1, then assert op_go for exactly 1 cycle and enter RUN.
REQ-019 RUN SHALL wait for tile_done=1; if ofmap_words=0 it SHALL enter FIN, otherwise it SHALL enter RD_ADDR.
REQ-020 RD_ADDR SHALL drive ofmap_en=1 and ofmap_addrin=read index for 1 cycle, then enter RD_DATA.
REQ-021 RD_DATA SHALL register ofmap_dout into out_data on entry (1-cycle BRAM latency) and hold out_valid=1 with out_data stable until out_ready=1.
REQ-022 On the RD_DATA handshake the read index SHALL increment; the block SHALL return to RD_ADDR if the index is below ofmap_words, otherwise enter FIN; throughput is therefore 1 word per 2 cycles minimum.
REQ-023 FIN SHALL assert op_done and done for 1 cycle, then enter IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Counters SHALL be 10 bits; a count of 1023 SHALL complete without wrap, and addresses SHALL never exceed count-1.
REQ-026 tile_done or dataload_ready arriving outside its waiting state SHALL be ignored and not remembered.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, clear all counters, and drive every output to 0 (out_data included), at any time including mid-phase.
REQ-028 After rst is released, no accelerator strobe SHALL issue until a new start.

Configuration
REQ-029 Macro SEQ_BIAS_LOAD_EN defined: the BIAS state SHALL be present as specified.
REQ-030 Macro SEQ_BIAS_LOAD_EN undefined: the BIAS state SHALL be removed, CFG SHALL go directly to WGHT, and bias_write SHALL be tied to 0.

Verification
REQ-031 Reset while in WGHT after 3 words -> next cycle state=IDLE, all outputs 0, and a subsequent start restarts at wght_addrin=0.
REQ-032 start with wght=4, ifmap=6, ofmap=3, stream always valid, out_ready=1 -> 2 bias writes, wght_addrin 0..3, one wght_ready pulse, ifmap_addrin 0..5, one ifmap_ready pulse, one op_go, 3 out words equal to ofmap_dout at addresses 0..2, one done pulse.
REQ-033 in_valid toggling 1/0 every cycle during IFMAP with ifmap=6 -> exactly 6 writes, at addresses 0..5 with no gaps or duplicates.
REQ-034 out_ready held 0 for 5 cycles on the first read word -> out_valid stays 1, out_data stays unchanged, and ofmap_addrin does not advance.
REQ-035 ifmap=0, ofmap=0 -> no ifmap_en writes, one ifmap_ready pulse, RUN goes to FIN on tile_done, out_valid never 1.
REQ-036 Build without SEQ_BIAS_LOAD_EN -> bias_write is never 1, and the first accepted word is a weight word at wght_addrin=0.
